axis_conv_stream_ctrl: RTL and testbench

Second-generation AXI-Stream control shell for the 2D frame convolver. It sits between the DMA streams and a fixed-latency convolution core. It adds:
- real backpressure, via credit-gated input and an output FIFO;
- frame tracking, with TLAST generation and checking;
- kernel-select changes applied only at frame boundaries.

It replaces the old loopback valid/ready scheme, which dropped data whenever the master stalled.

---
 rtl/axis_conv_stream_ctrl.sv | 175 +++++++++++++++++
 tb/tb_axis_conv_stream_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_conv_stream_ctrl.sv
// AXI-Stream control shell for the 2D frame convolver: credit-gated input, fixed-latency
// core tracking pipe, FWFT output FIFO, frame counting and frame-boundary kernel select.
module axis_conv_stream_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NB_SEL       = 2,
    parameter int CORE_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_BEATS  = 50
) (
    input  logic                  axi_clk,
    input  logic                  i_rst,
    input  logic                  s0_axis_valid,
    input  logic [DATA_WIDTH-1:0] s0_axis_data,
    input  logic                  s0_axis_last,
    output logic                  s0_axis_ready,
    input  logic                  s1_axis_valid,
    input  logic [DATA_WIDTH-1:0] s1_axis_data,
    output logic                  s1_axis_ready,
    output logic                  m0_axis_valid,
    output logic [DATA_WIDTH-1:0] m0_axis_data,
    output logic                  m0_axis_last,
    input  logic                  m0_axis_ready,
    output logic                  o_core_valid,
    output logic [DATA_WIDTH-1:0] o_core_data,
    output logic                  o_core_sof,
    output logic [NB_SEL-1:0]     o_core_kernel_sel,
    input  logic [DATA_WIDTH-1:0] i_core_data,
    output logic [NB_SEL-1:0]     o_kernel_sel_active,
    output logic                  o_frame_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W  = $clog2(CORE_LATENCY + 1);
    localparam int SUM_W  = $clog2(FIFO_DEPTH + CORE_LATENCY + 1);
    localparam int BEAT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(FRAME_BEATS - 1);
    localparam logic [SUM_W-1:0]  DEPTH_S  = SUM_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0]   fifo_data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   fifo_last_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        fifo_count_r;
    logic [INF_W-1:0]        inflight_r;
    logic [CORE_LATENCY-1:0] pipe_valid_r;
    logic [CORE_LATENCY-1:0] pipe_last_r;
    logic [BEAT_W-1:0]       beat_cnt_r;
    logic [NB_SEL-1:0]       active_r;
    logic [NB_SEL-1:0]       pending_r;
    logic                    pend_flag_r;
    logic                    frame_err_r;

    logic [SUM_W-1:0]        occupancy_s;
    logic                    acc_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    first_beat_s;
    logic                    at_max_s;
    logic                    beat_last_s;
    logic [NB_SEL-1:0]       kernel_sel_s;
    logic                    unused_sel_bits_s;

    // Handshake, occupancy and kernel-select decode
    always_comb begin
        occupancy_s   = SUM_W'(fifo_count_r) + SUM_W'(inflight_r);
        s0_axis_ready = (occupancy_s < DEPTH_S);
        acc_s         = s0_axis_valid & s0_axis_ready;
        push_s        = pipe_valid_r[CORE_LATENCY-1];
        m0_axis_valid = (fifo_count_r != {CNT_W{1'b0}});
        pop_s         = m0_axis_valid & m0_axis_ready;
        first_beat_s  = (beat_cnt_r == {BEAT_W{1'b0}});
        at_max_s      = (beat_cnt_r == BEAT_MAX);
        beat_last_s   = s0_axis_last | at_max_s;
        if (pend_flag_r && first_beat_s) begin
            kernel_sel_s = pending_r;
        end else begin
            kernel_sel_s = active_r;
        end
    end

    assign s1_axis_ready       = 1'b1;
    assign m0_axis_data        = fifo_data_r[rd_ptr_r];
    assign m0_axis_last        = fifo_last_r[rd_ptr_r];
    assign o_core_valid        = acc_s;
    assign o_core_data         = s0_axis_data;
    assign o_core_sof          = acc_s & first_beat_s;
    assign o_core_kernel_sel   = kernel_sel_s;
    assign o_kernel_sel_active = active_r;
    assign o_frame_err         = frame_err_r;
    assign unused_sel_bits_s   = ^s1_axis_data[DATA_WIDTH-1:NB_SEL];

    // Latency pipe tracking which core cycles carry a real beat and its frame-end bit
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            pipe_valid_r <= {CORE_LATENCY{1'b0}};
            pipe_last_r  <= {CORE_LATENCY{1'b0}};
        end else begin
            pipe_valid_r[0] <= acc_s;
            pipe_last_r[0]  <= acc_s & beat_last_s;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_last_r[i]  <= pipe_last_r[i-1];
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge axi_clk) begin
        if (push_s) begin
            fifo_data_r[wr_ptr_r] <= i_core_data;
            fifo_last_r[wr_ptr_r] <= pipe_last_r[CORE_LATENCY-1];
        end
    end

    // FIFO pointers, FIFO count and in-flight count (the credit state)
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            fifo_count_r <= {CNT_W{1'b0}};
            inflight_r   <= {INF_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
                2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
                default: fifo_count_r <= fifo_count_r;
            endcase
            case ({acc_s, push_s})
                2'b10:   inflight_r <= inflight_r + INF_W'(1);
                2'b01:   inflight_r <= inflight_r - INF_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Frame beat counter and sticky TLAST mismatch flag
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            beat_cnt_r  <= {BEAT_W{1'b0}};
            frame_err_r <= 1'b0;
        end else if (acc_s) begin
            beat_cnt_r <= beat_last_s ? {BEAT_W{1'b0}} : (beat_cnt_r + BEAT_W'(1));
            if (s0_axis_last != at_max_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

    // Kernel select: latch requests, commit only on the first beat of a frame
    always_ff @(posedge axi_clk) begin
        if (i_rst) begin
            active_r    <= {NB_SEL{1'b0}};
            pending_r   <= {NB_SEL{1'b0}};
            pend_flag_r <= 1'b0;
        end else begin
            if (acc_s && first_beat_s) begin
                active_r    <= kernel_sel_s;
                pend_flag_r <= 1'b0;
            end
            // A request arriving with the first beat is kept for the following frame
            if (s1_axis_valid) begin
                pending_r   <= s1_axis_data[NB_SEL-1:0];
                pend_flag_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_conv_stream_ctrl.sv
// Directed bench for axis_conv_stream_ctrl: frame table with kernel/TLAST expectations,
// scoreboard on the result stream, plus backpressure, latency and mid-frame reset sequences.
module tb_axis_conv_stream_ctrl;

    logic        axi_clk = 1'b0;
    logic        i_rst;
    logic        s0_axis_valid, s0_axis_last, s0_axis_ready;
    logic [31:0] s0_axis_data;
    logic        s1_axis_valid, s1_axis_ready;
    logic [31:0] s1_axis_data;
    logic        m0_axis_valid, m0_axis_last, m0_axis_ready;
    logic [31:0] m0_axis_data;
    logic        o_core_valid, o_core_sof, o_frame_err;
    logic [31:0] o_core_data, i_core_data;
    logic [1:0]  o_core_kernel_sel, o_kernel_sel_active;

    logic [31:0] core_d1, core_d2;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          tb_cnt = 0;
    logic [32:0] exp_q[$];

    logic        meas_on = 1'b0;
    int          meas_acc = 0, meas_pops = 0;
    int          first_acc_cyc = 0, first_out_cyc = 0, last_out_cyc = 0;

    typedef struct {
        int          nbeats;
        int          last_at;
        int          s1_at;
        logic [31:0] s1_val;
        logic [1:0]  ksel_first;
        logic [1:0]  ksel_rest;
        logic [1:0]  active_after;
        logic        err_after;
    } frame_t;
    frame_t frames[6];

    always #5 axi_clk = ~axi_clk;

    axis_conv_stream_ctrl dut (
        .axi_clk(axi_clk), .i_rst(i_rst),
        .s0_axis_valid(s0_axis_valid), .s0_axis_data(s0_axis_data),
        .s0_axis_last(s0_axis_last), .s0_axis_ready(s0_axis_ready),
        .s1_axis_valid(s1_axis_valid), .s1_axis_data(s1_axis_data),
        .s1_axis_ready(s1_axis_ready),
        .m0_axis_valid(m0_axis_valid), .m0_axis_data(m0_axis_data),
        .m0_axis_last(m0_axis_last), .m0_axis_ready(m0_axis_ready),
        .o_core_valid(o_core_valid), .o_core_data(o_core_data),
        .o_core_sof(o_core_sof), .o_core_kernel_sel(o_core_kernel_sel),
        .i_core_data(i_core_data),
        .o_kernel_sel_active(o_kernel_sel_active), .o_frame_err(o_frame_err)
    );

    // Two-cycle core model: result = input + 1
    always @(posedge axi_clk) begin
        core_d1 <= o_core_data + 32'd1;
        core_d2 <= core_d1;
        cyc     <= cyc + 1;
    end
    assign i_core_data = core_d2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected results queued at input handshakes, compared at output handshakes
    always @(negedge axi_clk) begin
        if (i_rst) begin
            exp_q.delete();
            tb_cnt <= 0;
        end else begin
            if (m0_axis_valid && m0_axis_ready) begin
                if (exp_q.size() == 0) begin
                    chk("m0_unexpected_beat", m0_axis_data, 32'hFFFF_FFFF);
                end else begin
                    chk("m0_data", m0_axis_data, exp_q[0][31:0]);
                    chk("m0_last", {31'd0, m0_axis_last}, {31'd0, exp_q[0][32]});
                    void'(exp_q.pop_front());
                end
                if (meas_on && meas_pops < 50) begin
                    if (meas_pops == 0) first_out_cyc <= cyc;
                    if (meas_pops == 49) last_out_cyc <= cyc;
                    meas_pops <= meas_pops + 1;
                end
            end
            if (s0_axis_valid && s0_axis_ready) begin
                chk("core_valid", {31'd0, o_core_valid}, 32'd1);
                chk("core_sof", {31'd0, o_core_sof}, (tb_cnt == 0) ? 32'd1 : 32'd0);
                exp_q.push_back({(s0_axis_last || tb_cnt == 49), s0_axis_data + 32'd1});
                tb_cnt <= (s0_axis_last || tb_cnt == 49) ? 0 : tb_cnt + 1;
                if (meas_on && meas_acc == 0) begin
                    first_acc_cyc <= cyc;
                    meas_acc <= 1;
                end
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic l, input logic s1v,
                             input logic [31:0] s1d, input logic [1:0] exp_ksel);
        int n = 0;
        s0_axis_valid = 1'b1;
        s0_axis_data  = d;
        s0_axis_last  = l;
        while (!s0_axis_ready && n < 64) begin
            @(posedge axi_clk); #1;
            n++;
        end
        if (!s0_axis_ready) chk("s0_ready_timeout", {31'd0, s0_axis_ready}, 32'd1);
        s1_axis_valid = s1v;
        s1_axis_data  = s1d;
        chk("core_kernel_sel", {30'd0, o_core_kernel_sel}, {30'd0, exp_ksel});
        @(posedge axi_clk); #1;
        s0_axis_valid = 1'b0;
        s0_axis_last  = 1'b0;
        s1_axis_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m0_axis_ready = 1'b1;
        while ((exp_q.size() != 0 || m0_axis_valid) && n < 64) begin
            @(posedge axi_clk); #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        frames[0] = '{50, 49, -1, 32'd0, 2'd0, 2'd0, 2'd0, 1'b0};
        frames[1] = '{50, 49, 10, 32'd2, 2'd0, 2'd0, 2'd0, 1'b0};
        frames[2] = '{30, 29, -1, 32'd0, 2'd2, 2'd2, 2'd2, 1'b1};
        frames[3] = '{50, 49,  5, 32'd1, 2'd2, 2'd2, 2'd2, 1'b1};
        frames[4] = '{50, 49,  0, 32'd3, 2'd1, 2'd1, 2'd1, 1'b1};
        frames[5] = '{50, 49, -1, 32'd0, 2'd3, 2'd3, 2'd3, 1'b1};

        i_rst = 1'b1;
        s0_axis_valid = 1'b0; s0_axis_data = 32'd0; s0_axis_last = 1'b0;
        s1_axis_valid = 1'b0; s1_axis_data = 32'd0; m0_axis_ready = 1'b1;
        repeat (3) @(posedge axi_clk);
        #1 i_rst = 1'b0;

        chk("rst_m0_valid", {31'd0, m0_axis_valid}, 32'd0);
        chk("rst_s0_ready", {31'd0, s0_axis_ready}, 32'd1);
        chk("rst_s1_ready", {31'd0, s1_axis_ready}, 32'd1);
        chk("rst_core_valid", {31'd0, o_core_valid}, 32'd0);
        chk("rst_active", {30'd0, o_kernel_sel_active}, 32'd0);
        chk("rst_frame_err", {31'd0, o_frame_err}, 32'd0);

        meas_on = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < frames[f].nbeats; b++) begin
                send_beat(32'(f * 256 + b), (b == frames[f].last_at), (b == frames[f].s1_at),
                          frames[f].s1_val, (b == 0) ? frames[f].ksel_first : frames[f].ksel_rest);
            end
            chk("frame_active", {30'd0, o_kernel_sel_active}, {30'd0, frames[f].active_after});
            chk("frame_err", {31'd0, o_frame_err}, {31'd0, frames[f].err_after});
        end
        drain();
        chk("lat_first_out", first_out_cyc - first_acc_cyc, 32'd3);
        chk("no_bubbles", last_out_cyc - first_out_cyc, 32'd49);
        chk("meas_pops", meas_pops, 32'd50);

        // Backpressure: stalled sink lets exactly FIFO_DEPTH beats in
        m0_axis_ready = 1'b0;
        acc_cnt = 0;
        s0_axis_valid = 1'b1;
        for (int c = 0; c < 26; c++) begin
            if (c == 10) begin
                chk("bp_accepted", acc_cnt, 32'd4);
                chk("bp_ready_low", {31'd0, s0_axis_ready}, 32'd0);
                chk("bp_m0_valid", {31'd0, m0_axis_valid}, 32'd1);
                m0_axis_ready = 1'b1;
            end
            s0_axis_data = 32'h5000 + 32'(acc_cnt);
            if (s0_axis_ready) acc_cnt++;
            @(posedge axi_clk); #1;
        end
        s0_axis_valid = 1'b0;
        drain();

        // Mid-frame reset with beats both in the core pipe and in the FIFO
        m0_axis_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            s0_axis_valid = 1'b1;
            s0_axis_data  = 32'h6000 + 32'(c);
            chk("pre_reset_ready", {31'd0, s0_axis_ready}, 32'd1);
            @(posedge axi_clk); #1;
        end
        s0_axis_valid = 1'b0;
        chk("pre_reset_m0_valid", {31'd0, m0_axis_valid}, 32'd1);
        i_rst = 1'b1;
        @(posedge axi_clk); #1;
        i_rst = 1'b0;
        chk("post_rst_m0_valid", {31'd0, m0_axis_valid}, 32'd0);
        chk("post_rst_s0_ready", {31'd0, s0_axis_ready}, 32'd1);
        chk("post_rst_active", {30'd0, o_kernel_sel_active}, 32'd0);
        chk("post_rst_frame_err", {31'd0, o_frame_err}, 32'd0);
        repeat (5) @(posedge axi_clk);
        #1;
        chk("post_rst_no_stale", {31'd0, m0_axis_valid}, 32'd0);
        m0_axis_ready = 1'b1;
        for (int b = 0; b < 50; b++) begin
            send_beat(32'h7000 + 32'(b), (b == 49), 1'b0, 32'd0, 2'd0);
        end
        drain();
        chk("post_rst_frame_err_end", {31'd0, o_frame_err}, 32'd0);
        chk("post_rst_active_end", {30'd0, o_kernel_sel_active}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
